alto_banked_registers: RTL and testbench
========================================

// Module: alto_banked_registers
// PURPOSE
//  Next-generation R-register file: a parametrised array of BANKS x DEPTH words, one bank per task.
//  Writes pass through a one-deep commit register to fit synchronous-RAM timing.
//  After reset the array is cleared by hardware.
//  Sits on the processor bus beside the ALU and is controlled by the BS field and RSEL of each microinstruction.
// PARAMETERS
//  DATA_W  16  word width; bus width of dat_i/dat_o
//  ADDR_W  5   register select width; DEPTH = 2**ADDR_W words per bank
//  BANK_W  3   bank select width; BANKS = 2**BANK_W; flat index = {bank_i, rsel_i}
// PORTS
//  clk_i    in   1          single clock, all state on posedge
//  rst_ni   in   1          asynchronous, active-low reset
//  bs_i     in   3          bus source; ALTO_BS_READ_R / ALTO_BS_LOAD_R from alto_definitions.v
//  rsel_i   in   ADDR_W     register select within bank
//  bank_i   in   BANK_W     bank (task) select
//  dat_i    in   DATA_W     write data (bus value)
//  dat_o    out  DATA_W     bus contribution (wired-AND bus: idle = all ones)
//  stall_i  in   1          1 = suppress capture of a new load this cycle
//  busy_o   out  1          1 = clear sequence in progress, accesses ignored
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=CLEAR, clr_cnt=0, pending valid=0 (pending write discarded),
//   busy_o=1, dat_o=all ones. Reset mid-clear or mid-write restarts the clear from index 0.
//  CLEAR state:
//   - each posedge writes 0 to mem[clr_cnt] and increments clr_cnt (width BANK_W+ADDR_W).
//   - on the edge writing the last index (BANKS*DEPTH-1), go to RUN; busy_o falls on that edge.
//   - busy_o=1 for exactly BANKS*DEPTH cycles after rst_ni rises.
//   - bs_i, stall_i and dat_i are ignored; dat_o=all ones.
//  RUN state, dat_o (combinational):
//   - bs_i==READ_R: read data for {bank_i,rsel_i}.
//   - bs_i==LOAD_R: 0.
//   - any other bs_i: all ones.
//  RUN state, write pipeline:
//   - stage 1 (capture): posedge with bs_i==LOAD_R && !stall_i captures pend_addr={bank_i,rsel_i},
//     pend_dat=dat_i, and sets pend_v=1; otherwise pend_v is cleared.
//   - stage 2 (commit): posedge with pend_v=1 writes mem[pend_addr]<=pend_dat.
//     Commit is not gated by stall_i.
//   - a new capture and the commit of the previous one may occur on the same edge.
//     Back-to-back loads to the same address leave the later value in the array.
//   - write latency: 2 edges from capture to array.
//  Read data:
//   - array content, or the forwarded pend_dat when pend_v && pend_addr=={bank_i,rsel_i}
//     (see CONFIGURATION).
//   - a read never sees the value being driven on dat_i in the same cycle.
//  Width: no arithmetic on data. Index wraps only within clr_cnt; RUN never wraps.
// CONFIGURATION
//  ALTO_REG_BYPASS_EN defined:
//   - read of an address with a pending write returns pend_dat.
//   - a LOAD followed by a READ of the same register on the next cycle returns the new value.
//  ALTO_REG_BYPASS_EN undefined:
//   - no forwarding; that READ returns the old array value (one-cycle hazard).
//   - the value is correct one cycle later. Microcode must schedule around the hazard.
// TESTING (DATA_W=16, ADDR_W=5, BANK_W=3, 256 entries)
//  1. Reset release -> busy_o=1 for exactly 256 cycles then 0; READ of every {bank,rsel} = 16'h0000.
//  2. LOAD bank2 r5 16'h1234, next cycle READ bank2 r5 -> 16'h1234 (bypass);
//     READ bank3 r5 -> 16'h0000.
//  3. LOAD bank0 r7 16'hBEEF with stall_i=1 -> later READ bank0 r7 = 16'h0000.
//  4. bs_i=LOAD_R -> dat_o=16'h0000; bs_i not READ_R/LOAD_R -> 16'hFFFF; dat_o=16'hFFFF while busy_o=1.
//  5. LOAD bank1 r3 16'hA5A5, assert rst_ni=0 on the next cycle, release -> full 256-cycle clear,
//     then READ bank1 r3 = 16'h0000.
//  6. Without ALTO_REG_BYPASS_EN: bank4 r1 holds 16'h0001; LOAD 16'h0002, next-cycle READ -> 16'h0001,
//     cycle after -> 16'h0002.

Source files
------------

// File: rtl/alto_reg_if.sv
// Bus-side signals of the banked R-register file: microinstruction controls in,
// wired-AND bus contribution and clear-busy flag out.
interface alto_reg_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int BANK_W = 3
);
  logic [2:0]        bs_i;
  logic [ADDR_W-1:0] rsel_i;
  logic [BANK_W-1:0] bank_i;
  logic [DATA_W-1:0] dat_i;
  logic [DATA_W-1:0] dat_o;
  logic              stall_i;
  logic              busy_o;

  modport master (output bs_i, rsel_i, bank_i, dat_i, stall_i, input dat_o, busy_o);
  modport slave  (input bs_i, rsel_i, bank_i, dat_i, stall_i, output dat_o, busy_o);
endinterface

// File: rtl/alto_banked_registers.sv
// Banked R-register file (BANKS x DEPTH words) with a one-deep write commit stage and
// hardware clear after reset. Define ALTO_REG_BYPASS_EN to forward the pending write to reads.
module alto_banked_registers #(
  parameter int         DATA_W    = 16,
  parameter int         ADDR_W    = 5,
  parameter int         BANK_W    = 3,
  parameter logic [2:0] BS_READ_R = 3'd0,
  parameter logic [2:0] BS_LOAD_R = 3'd1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  alto_reg_if.slave  bus
);
  localparam int IDX_W   = BANK_W + ADDR_W;
  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic [IDX_W-1:0]  pend_addr_q;
  logic [DATA_W-1:0] pend_dat_q;
  logic              pend_v_q;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_dat;
  logic              capture;
  logic [DATA_W-1:0] mem [ENTRIES];

  assign rd_addr = {bus.bank_i, bus.rsel_i};
  assign capture = (state_q == ST_RUN) && (bus.bs_i == BS_LOAD_R) && !bus.stall_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_dat_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= capture;
      if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + IDX_W'(1);
      if (capture) begin
        pend_addr_q <= rd_addr;
        pend_dat_q  <= bus.dat_i;
      end
    end
  end

  // Array has no reset; the CLEAR sweep initialises it, then the commit stage owns the port.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR)
      mem[clr_cnt_q] <= '0;
    else if (pend_v_q)
      mem[pend_addr_q] <= pend_dat_q;
  end

`ifdef ALTO_REG_BYPASS_EN
  assign rd_dat = (pend_v_q && pend_addr_q == rd_addr) ? pend_dat_q : mem[rd_addr];
`else
  assign rd_dat = mem[rd_addr];
`endif

  always_comb begin
    state_d    = state_q;
    bus.busy_o = 1'b0;
    bus.dat_o  = '1;
    case (state_q)
      ST_CLEAR: begin
        bus.busy_o = 1'b1;
        if (clr_cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.bs_i == BS_READ_R)      bus.dat_o = rd_dat;
        else if (bus.bs_i == BS_LOAD_R) bus.dat_o = '0;
      end
      default: state_d = ST_CLEAR;
    endcase
  end
endmodule

// File: tb/tb_alto_banked_registers.sv
// Randomised bench for alto_banked_registers against a write-visibility model
// (each load becomes readable a fixed number of edges after capture).
module tb_alto_banked_registers;
  localparam int         DATA_W  = 16;
  localparam int         ADDR_W  = 5;
  localparam int         BANK_W  = 3;
  localparam int         DEPTH   = 32;
  localparam int         ENTRIES = 256;
  localparam logic [2:0] BS_READ = 3'd0;
  localparam logic [2:0] BS_LOAD = 3'd1;
  localparam logic [2:0] BS_OTH  = 3'd4;
`ifdef ALTO_REG_BYPASS_EN
  localparam longint HAZ = 0;
`else
  localparam longint HAZ = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alto_reg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

  alto_banked_registers #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W),
    .BS_READ_R(BS_READ), .BS_LOAD_R(BS_LOAD)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  int     checks = 0;
  int     errors = 0;
  longint edge_cnt = 0;

  typedef struct {
    int          idx;
    logic [15:0] d;
    longint      vis;
  } wr_t;

  logic [15:0] ref_mem [ENTRIES];
  wr_t         wq [$];

  function automatic void retire();
    while (wq.size() > 0 && wq[0].vis <= edge_cnt) begin
      ref_mem[wq[0].idx] = wq[0].d;
      void'(wq.pop_front());
    end
  endfunction

  // One bus cycle in RUN: drive, check combinational output mid-cycle, advance the model on the edge.
  task automatic op(input logic [2:0] bs, input int bank, input int rsel,
                    input logic [15:0] d, input logic stall, input string nm);
    logic [15:0] exp;
    bus.bs_i    = bs;
    bus.bank_i  = 3'(bank);
    bus.rsel_i  = 5'(rsel);
    bus.dat_i   = d;
    bus.stall_i = stall;
    @(negedge clk);
    exp = (bs == BS_READ) ? ref_mem[bank*DEPTH + rsel] : (bs == BS_LOAD) ? 16'h0000 : 16'hFFFF;
    checks++;
    if (bus.dat_o !== exp) begin
      errors++;
      $display("FAIL %s dat_o got %h exp %h (bs %0d bank %0d r %0d)", nm, bus.dat_o, exp, bs, bank, rsel);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_o got %b exp 0", nm, bus.busy_o);
    end
    @(posedge clk);
    edge_cnt++;
    if (bs == BS_LOAD && !stall) wq.push_back('{bank*DEPTH + rsel, d, edge_cnt + HAZ});
    retire();
    #1;
  endtask

  task automatic do_reset(input string nm);
    int cnt;
    rst_n = 1'b0;
    bus.bs_i = BS_LOAD; bus.stall_i = 1'b0; bus.dat_i = 16'h5555;
    #1;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.dat_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL %s in reset busy/dat_o got %b/%h exp 1/ffff", nm, bus.busy_o, bus.dat_o);
    end
    @(posedge clk); edge_cnt++;
    #1;
    rst_n = 1'b1;
    foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
    wq.delete();
    cnt = 0;
    while (bus.busy_o === 1'b1 && cnt < 1000) begin
      checks++;
      if (bus.dat_o !== 16'hFFFF) begin
        errors++;
        $display("FAIL %s dat_o during clear got %h exp ffff", nm, bus.dat_o);
      end
      bus.bs_i    = 3'($urandom_range(0, 7));
      bus.bank_i  = 3'($urandom);
      bus.rsel_i  = 5'($urandom);
      bus.dat_i   = 16'($urandom);
      bus.stall_i = 1'($urandom);
      @(posedge clk); edge_cnt++;
      cnt++;
      #1;
    end
    checks++;
    if (cnt != ENTRIES) begin
      errors++;
      $display("FAIL %s busy cycles got %0d exp %0d", nm, cnt, ENTRIES);
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
    for (int i = 0; i < ENTRIES; i++) op(BS_READ, i / DEPTH, i % DEPTH, 16'hFFFF, 1'b0, "clear_read");
  endtask

  task automatic test_bypass();
    op(BS_LOAD, 2, 5, 16'h1234, 1'b0, "byp_load");
    op(BS_READ, 2, 5, 16'h0000, 1'b0, "byp_read_next");
    op(BS_READ, 3, 5, 16'h0000, 1'b0, "byp_other_bank");
    op(BS_READ, 2, 5, 16'h0000, 1'b0, "byp_read_later");
  endtask

  task automatic test_stall();
    op(BS_LOAD, 0, 7, 16'hBEEF, 1'b1, "stall_load");
    op(BS_OTH,  0, 0, 16'h0000, 1'b0, "stall_idle");
    op(BS_READ, 0, 7, 16'h0000, 1'b0, "stall_read");
    op(BS_READ, 0, 7, 16'h0000, 1'b0, "stall_read2");
  endtask

  task automatic test_dat_o_codes();
    for (int b = 0; b < 8; b++) op(3'(b), 5, 9, 16'h0F0F, 1'b1, "bs_code");
  endtask

  task automatic test_reset_mid_write();
    op(BS_LOAD, 1, 3, 16'hA5A5, 1'b0, "mid_load");
    do_reset("mid_reset");
    op(BS_READ, 1, 3, 16'h0000, 1'b0, "mid_read");
    op(BS_READ, 1, 3, 16'h0000, 1'b0, "mid_read2");
  endtask

  task automatic test_hazard();
    op(BS_LOAD, 4, 1, 16'h0001, 1'b0, "haz_init");
    op(BS_OTH,  0, 0, 16'h0000, 1'b0, "haz_idle");
    op(BS_OTH,  0, 0, 16'h0000, 1'b0, "haz_idle2");
    op(BS_LOAD, 4, 1, 16'h0002, 1'b0, "haz_load");
    op(BS_READ, 4, 1, 16'h0000, 1'b0, "haz_read_next");
    op(BS_READ, 4, 1, 16'h0000, 1'b0, "haz_read_after");
  endtask

  task automatic test_back_to_back();
    op(BS_LOAD, 6, 30, 16'h1111, 1'b0, "b2b_load1");
    op(BS_LOAD, 6, 30, 16'h2222, 1'b0, "b2b_load2");
    op(BS_LOAD, 6, 31, 16'h3333, 1'b0, "b2b_load3");
    op(BS_READ, 6, 30, 16'h0000, 1'b0, "b2b_read");
    op(BS_READ, 6, 31, 16'h0000, 1'b0, "b2b_read2");
    op(BS_READ, 6, 30, 16'h0000, 1'b0, "b2b_read3");
  endtask

  task automatic test_random();
    logic [2:0] bs;
    int r;
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 9));
      bs = (r < 4) ? BS_READ : (r < 8) ? BS_LOAD : 3'($urandom_range(2, 7));
      op(bs, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 16'($urandom),
         1'($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    bus.bs_i = BS_OTH; bus.bank_i = '0; bus.rsel_i = '0; bus.dat_i = '0; bus.stall_i = 1'b0;
    test_reset();
    test_bypass();
    test_stall();
    test_dat_o_codes();
    test_reset_mid_write();
    test_hazard();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
